// File: rtl/ps2_keyboard_rx_if.sv
// Receiver-to-user bundle for the PS/2 keyboard receiver: raw byte stream,
// error pulses, busy, and the decoded key event.
interface ps2_keyboard_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       busy;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;

  modport master (
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, busy,
    output key_code, key_ext, key_release, key_valid
  );

  modport slave (
    input rx_data, rx_valid, rx_parity_err, rx_frame_err, busy,
    input key_code, key_ext, key_release, key_valid
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the raw pins, deframes
// 11-bit device-to-host frames and decodes E0/F0 prefixed key events.
module ps2_keyboard_rx #(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master rx
);

  localparam int unsigned FILT_W  = $clog2(FILT_LEN + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BCNT_W  = 3;
  localparam logic [BYTE_W-1:0] PREFIX_EXT = 8'hE0;
  localparam logic [BYTE_W-1:0] PREFIX_REL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // input path
  logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              edge_c;
  logic              bit_c;

  // deframer
  state_e            state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              ext_q, ext_d;
  logic              rel_q, rel_d;

  // registered outputs
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] key_code_q, key_code_d;
  logic              key_ext_q, key_ext_d;
  logic              key_rel_q, key_rel_d;
  logic              key_valid_q, key_valid_d;

  // Two-stage synchronisers; the clock line additionally passes a run-length filter.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FILT_W'(FILT_LEN - 1)) begin
        filt_d = ~filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end
  end

  assign edge_c = filt_q & ~filt_d;
  assign bit_c  = dat_s2_q;

  // Frame state machine, timeout and key decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    to_cnt_d    = '0;
    ext_d       = ext_q;
    rel_d       = rel_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    key_valid_d = 1'b0;

    if (edge_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bit_c) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {bit_c, shift_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == BCNT_W'(BYTE_W - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = bit_c;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (^{shift_q, parity_q} != 1'b1) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end else if (!bit_c) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (shift_q == PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PREFIX_REL) begin
              rel_d = 1'b1;
            end else begin
              key_code_d  = shift_q;
              key_ext_d   = ext_q;
              key_rel_d   = rel_q;
              key_valid_d = 1'b1;
              ext_d       = 1'b0;
              rel_d       = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled frame is abandoned; the partial byte is never reported.
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        state_d = ST_IDLE;
        ferr_d  = 1'b1;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign rx.rx_data       = rx_data_q;
  assign rx.rx_valid      = rx_valid_q;
  assign rx.rx_parity_err = perr_q;
  assign rx.rx_frame_err  = ferr_q;
  assign rx.busy          = busy_q;
  assign rx.key_code      = key_code_q;
  assign rx.key_ext       = key_ext_q;
  assign rx.key_release   = key_rel_q;
  assign rx.key_valid     = key_valid_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames on the pins and
// checks byte, error and key-event outputs against hand-computed values.
module tb_ps2_keyboard_rx;
  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 1000;
  localparam int unsigned HALF = 40;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_key = 0;
  int n_long = 0, n_key_solo = 0, n_busy = 0;
  int ferr_cyc = 0, last_fall = 0, busy_base = 0;
  logic prev_valid = 1'b0;

  ps2_keyboard_rx_if rx_if ();

  ps2_keyboard_rx #(.FILT_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_if.rx_valid) n_valid++;
    if (rx_if.rx_valid && prev_valid) n_long++;
    prev_valid = rx_if.rx_valid;
    if (rx_if.rx_parity_err) n_perr++;
    if (rx_if.rx_frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (rx_if.key_valid) n_key++;
    if (rx_if.key_valid && !rx_if.rx_valid) n_key_solo++;
    if (rx_if.busy) n_busy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(frame(b, 1'b0, 1'b1), 11);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(4);
    chk("reset_outputs", {rx_if.rx_data, rx_if.key_code, rx_if.rx_valid, rx_if.rx_parity_err,
        rx_if.rx_frame_err, rx_if.busy, rx_if.key_ext, rx_if.key_release, rx_if.key_valid}, 32'h0);
    reset = 1'b0;
    wait_cyc(5);

    // single make code
    send(8'h1C);
    chk("t1_valid_cnt", n_valid, 1);
    chk("t1_rx_data", rx_if.rx_data, 8'h1C);
    chk("t1_key_cnt", n_key, 1);
    chk("t1_key", {rx_if.key_code, rx_if.key_ext, rx_if.key_release}, {8'h1C, 2'b00});

    // extended break, then plain make
    send(8'hE0);
    chk("t2_prefix_no_key", n_key, 1);
    chk("t2_busy_after_prefix", rx_if.busy, 1'b0);
    send(8'hF0);
    send(8'h75);
    chk("t2_valid_cnt", n_valid, 4);
    chk("t2_key_cnt", n_key, 2);
    chk("t2_key_ext_rel", {rx_if.key_code, rx_if.key_ext, rx_if.key_release}, {8'h75, 2'b11});
    send(8'h75);
    chk("t2_flags_cleared", {rx_if.key_code, rx_if.key_ext, rx_if.key_release}, {8'h75, 2'b00});
    send(8'hE0);
    send(8'hE0);
    send(8'h75);
    chk("t2_repeat_prefix_cnt", {n_valid[7:0], n_key[7:0]}, {8'd8, 8'd4});
    chk("t2_repeat_prefix_key", {rx_if.key_code, rx_if.key_ext, rx_if.key_release}, {8'h75, 2'b10});

    // parity error discards byte and pending break flag
    send(8'hF0);
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
    chk("t3_perr_cnt", n_perr, 1);
    chk("t3_no_valid", n_valid, 9);
    chk("t3_rx_data_held", rx_if.rx_data, 8'hF0);
    send(8'h1C);
    chk("t3_rel_cleared", {rx_if.key_code, rx_if.key_ext, rx_if.key_release}, {8'h1C, 2'b00});
    chk("t3_key_cnt", n_key, 5);

    // bad stop bit
    send_bits(frame(8'h29, 1'b0, 1'b0), 11);
    chk("t4_ferr_cnt", n_ferr, 1);
    chk("t4_no_valid", n_valid, 10);
    chk("t4_busy_low", rx_if.busy, 1'b0);

    // stalled frame times out
    send_bits(frame(8'h29, 1'b0, 1'b1), 5);
    chk("t5_busy_mid", rx_if.busy, 1'b1);
    wait_cyc(TO + 100);
    chk("t5_ferr_cnt", n_ferr, 2);
    chk("t5_timeout_window", ((ferr_cyc - last_fall) >= TO) && ((ferr_cyc - last_fall) <= TO + 20), 1'b1);
    chk("t5_busy_low", rx_if.busy, 1'b0);
    send(8'h29);
    chk("t5_recover", {n_valid[7:0], rx_if.rx_data, rx_if.key_code}, {8'd11, 8'h29, 8'h29});

    // short glitch with data low must not start a frame
    busy_base = n_busy;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(5);
    ps2_clk  = 1'b1;
    wait_cyc(2);
    ps2_data = 1'b1;
    wait_cyc(30);
    chk("t6_glitch_busy", n_busy - busy_base, 0);
    chk("t6_glitch_pulses", {n_valid[7:0], n_perr[7:0], n_ferr[7:0]}, {8'd11, 8'd1, 8'd2});

    // reset mid-frame with a pending break prefix
    send(8'hF0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 4);
    chk("t6_busy_mid", rx_if.busy, 1'b1);
    reset = 1'b1;
    wait_cyc(3);
    chk("t6_reset_outputs", {rx_if.rx_data, rx_if.key_code, rx_if.rx_valid, rx_if.rx_parity_err,
        rx_if.rx_frame_err, rx_if.busy, rx_if.key_ext, rx_if.key_release, rx_if.key_valid}, 32'h0);
    reset = 1'b0;
    wait_cyc(5);
    send(8'h1C);
    chk("t6_after_reset_valid", n_valid, 13);
    chk("t6_after_reset_key", {rx_if.rx_data, rx_if.key_code, rx_if.key_ext, rx_if.key_release},
        {8'h1C, 8'h1C, 2'b00});

    chk("single_cycle_valid", n_long, 0);
    chk("key_with_valid", n_key_solo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
